adder16_seq_ctrl: RTL and testbench
===================================

// Module: adder16_seq_ctrl
// PURPOSE
//  Multi-cycle add/subtract unit. Time-shares one adder16 slice (16-bit add, carry in/out)
//  to produce a WIDTH-bit sum, one 16-bit slice per clock, LSB slice first.
//  The carry is registered between slices. Operands arrive on a valid/ready request port.
//  Results leave on a valid/ready response port.
//  Area-lean alternative to the carry-select adder for non-critical datapath users (e.g. CSR/counter updates).
// PARAMETERS
//  WIDTH   32  operand/result width; legal values are multiples of 16 that are >= 16
//  NSLICE  WIDTH/16  derived localparam, not overridable; number of CALC cycles
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid && in_ready at a clk edge
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      1: result = A - B (A + ~B + 1); 0: result = A + B
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes the result when out_valid && out_ready at a clk edge
//  out_sum    out  WIDTH  result, modulo 2^WIDTH
//  out_carry  out  1      carry out of MSB slice; for subtract, 1 = no borrow (A >= B unsigned)
//  busy       out  1      high in CALC or DONE
// BEHAVIOUR
//  Reset (async, rst_n low): state=IDLE, slice idx=0, carry reg=0, operand regs=0.
//   Reset values of outputs: out_sum=0, out_carry=0, out_valid=0, busy=0, in_ready=1 (rst_n high).
//   Reset takes effect immediately in any state. An operation in flight is discarded and no result is emitted.
//  FSM states: IDLE, CALC, DONE.
//   IDLE: in_ready=1. On accept:
//    - register in_a, and in_b (or ~in_b if in_sub)
//    - carry reg = in_sub; idx = 0; go to CALC
//   CALC: in_ready=0. Each cycle, adder16 gets:
//    - A[16*idx +: 16] and Bx[16*idx +: 16], where Bx is the registered B / ~B
//    - carry in = carry reg
//   At the edge, write out to out_sum[16*idx +: 16] and carry_out to carry reg.
//   If idx == NSLICE-1: out_carry = carry_out and go to DONE. Otherwise idx++.
//   DONE: out_valid=1, in_ready=0. On out_ready go to IDLE.
//  Latency: for accept at edge E, out_valid goes high after edge E+NSLICE.
//   With WIDTH=32 that is 2 cycles; with WIDTH=16 it is 1 cycle.
//  Throughput: at most one op per NSLICE+2 cycles. There is no DONE->accept bypass.
//  Stability:
//   - operands are captured at accept; later changes on in_a, in_b or in_sub have no effect
//   - out_sum and out_carry hold from DONE entry until the next accept, even after out_valid drops
//   - out_sum slices not yet written in CALC may hold stale data and are don't-care while out_valid=0
//  in_valid asserted while in_ready=0: ignored. The requester must hold its request until it is accepted.
//  out_ready asserted while out_valid=0: no effect.
//  Wrap-around: the sum is modulo 2^WIDTH and the overflow is visible only in out_carry. No signed-overflow flag.
// TESTING
//  T1 reset: drive rst_n=0 mid-cycle.
//   -> immediately out_valid=0, busy=0, out_sum=0, out_carry=0; in_ready=1 once rst_n=1.
//  T2 slice carry: A=0x0000FFFF, B=0x00000001, add.
//   -> out_valid high 2 edges after accept; out_sum=0x00010000, out_carry=0.
//  T3 full wrap: A=0xFFFFFFFF, B=0x00000001, add.
//   -> out_sum=0x00000000, out_carry=1.
//  T4 subtract borrow: A=5, B=7, sub.
//   -> out_sum=0xFFFFFFFE, out_carry=0.
//   A=7, B=5, sub -> out_sum=0x00000002, out_carry=1.
//  T5 backpressure: hold out_ready=0 for 5 cycles after out_valid; toggle in_a/in_valid meanwhile.
//   -> out_sum/out_valid stable and in_ready=0 throughout.
//   -> out_ready=1: IDLE next cycle; a held request is accepted on the following edge.
//  T6 reset mid-op: rst_n low during CALC (idx=1).
//   -> no out_valid pulse; a new op after release gives the correct result (A=0x12345678 + 0x11111111 = 0x23456789).

Source files
------------

// File: rtl/adder16_seq_ctrl.sv
// adder16_seq_ctrl
//   Multi-cycle add/subtract unit. A single 16-bit adder slice is reused once
//   per clock, LSB slice first, to build a WIDTH-bit result. The carry between
//   slices is kept in a register.
//
// Parameters
//   WIDTH      operand/result width, a multiple of 16 that is >= 16
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready at a clk edge
//   in_a       operand A
//   in_b       operand B
//   in_sub     1: result = A - B, 0: result = A + B
//   out_valid  result valid
//   out_ready  result taken when out_valid && out_ready at a clk edge
//   out_sum    result, modulo 2^WIDTH
//   out_carry  carry out of the MSB slice (for subtract, 1 = no borrow)
//   busy       high while an operation is calculating or waiting to be taken
module adder16_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 16;
  // Keep the index at least one bit wide so WIDTH=16 still elaborates.
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [15:0]      slice_a;
  logic [15:0]      slice_b;
  logic [15:0]      slice_sum;
  logic             slice_cout;

  // The shared adder slice: the current 16-bit window of A and B/~B plus the
  // carry left behind by the previous slice.
  always_comb begin
    slice_a = a_q[16*idx_q +: 16];
    slice_b = bx_q[16*idx_q +: 16];
    {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {16'd0, carry_q};
  end

  // Next-state logic. Subtraction is A + ~B + 1, so B is inverted at capture
  // and the +1 enters as the initial carry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    bx_d    = bx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          bx_d    = in_sub ? ~in_b : in_b;
          carry_d = in_sub;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[16*idx_q +: 16] = slice_sum;
        carry_d               = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered copies decoded from the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // All state and registered outputs. Reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      bx_q        <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      bx_q        <= bx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_carry = cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder16_seq_ctrl.sv
// tb_adder16_seq_ctrl
//   Directed-vector bench for adder16_seq_ctrl at WIDTH=32. Expected values are
//   hand-computed constants.
module tb_adder16_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
  logic        busy;

  int checkCount;
  int errorCount;

  adder16_seq_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request and hold it until accepted, then scribble over the
  // operand inputs so late changes would show up in the result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic sub);
    int waitCycles;
    waitCycles = 0;
    while (!in_ready && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("accept_timeout", 32'(waitCycles < 20), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = 32'hA5A5_5A5A;
    in_b     = 32'h3C3C_C3C3;
    in_sub   = ~sub;
  endtask

  // Called one step after the accept edge; expects out_valid after 2 edges.
  task automatic waitResult(input string tag, input logic [31:0] expSum,
                            input logic expCarry);
    int edges;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({tag, "_latency"}, 32'(edges), 32'd2);
    checkOutput({tag, "_sum"}, out_sum, expSum);
    checkOutput({tag, "_carry"}, 32'(out_carry), 32'(expCarry));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  // Take the result and confirm the unit returns to idle with the result held.
  task automatic takeResult(input string tag, input logic [31:0] expSum);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_hold_sum"}, out_sum, expSum);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] expSum, input logic expCarry);
    applyStimulus(a, b, sub);
    waitResult(tag, expSum, expCarry);
    takeResult(tag, expSum);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_sub     = 1'b0;
    out_ready  = 1'b0;

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("por_valid", 32'(out_valid), 32'd0);
    checkOutput("por_busy", 32'(busy), 32'd0);
    checkOutput("por_sum", out_sum, 32'd0);
    checkOutput("por_carry", 32'(out_carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("por_in_ready", 32'(in_ready), 32'd1);

    // T2: carry crosses from slice 0 into slice 1. Left waiting in DONE.
    applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    waitResult("t2", 32'h0001_0000, 1'b0);

    // T1: mid-cycle reset while a result is being held clears it at once.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_valid", 32'(out_valid), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_sum", out_sum, 32'd0);
    checkOutput("t1_carry", 32'(out_carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("t1_in_ready", 32'(in_ready), 32'd1);

    // T3: full wrap, T4: subtract with and without borrow.
    runOp("t3", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    runOp("t4a", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0);
    runOp("t4b", 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1);
    runOp("sub_xslice", 32'hFFFF_0000, 32'h0000_0001, 1'b1, 32'hFFFE_FFFF, 1'b1);
    runOp("sub_zero", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0);
    runOp("add_mixed", 32'h8001_7FFF, 32'h7FFF_8001, 1'b0, 32'h0001_0000, 1'b1);

    // T5: backpressure with requests toggling on the input port.
    applyStimulus(32'h0000_0003, 32'h0000_0004, 1'b0);
    waitResult("t5", 32'h0000_0007, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_a     = 32'h0000_0100 + 32'(i);
      in_b     = 32'h0000_0200;
      in_sub   = 1'b0;
      @(posedge clk); #1;
      checkOutput("t5_hold_sum", out_sum, 32'h0000_0007);
      checkOutput("t5_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("t5_hold_in_ready", 32'(in_ready), 32'd0);
    end
    // Held request: 0x100 + 0x200.
    in_valid  = 1'b1;
    in_a      = 32'h0000_0100;
    in_b      = 32'h0000_0200;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("t5_idle_ready", 32'(in_ready), 32'd1);
    checkOutput("t5_idle_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_idle_sum", out_sum, 32'h0000_0007);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = 32'hDEAD_0000;
    checkOutput("t5_accept_busy", 32'(busy), 32'd1);
    checkOutput("t5_accept_in_ready", 32'(in_ready), 32'd0);
    waitResult("t5b", 32'h0000_0300, 1'b0);
    takeResult("t5b", 32'h0000_0300);

    // T6: reset during the second slice; nothing must come out afterwards.
    applyStimulus(32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("t6_no_pulse", 32'(out_valid), 32'd0);
    end
    runOp("t6_new", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
